pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control unit for the KGP-RISC core. It decodes the ID-stage instruction into a control word and carries that word through the EX, MEM and WB stage registers. It also owns hazard handling: load-use and RAW stall detection, operand-forwarding selects, branch/jump flush and illegal-opcode trapping. It sits between the IF/ID register and the datapath, and replaces the single-stage negedge decoder.

## Interface
Parameters:
- REG_AW, default 5: register-address width; rs = instr[25:21], rt = instr[20:16], rd = instr[15:11] at default.
- ALUF_W, default 4: ALU function code width.
- FWD_EN, default 1: 1 = forwarding plus load-use stall only; 0 = no forwarding, stall on any RAW hazard against EX or MEM.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears every stage register.
- instr  in  32  instruction held in IF/ID.
- instr_valid  in  1  IF/ID holds a real instruction; 0 decodes as bubble.
- branch_condition  in  1  EX-stage comparison result from the ALU.
- ex_alusrc  out  1  EX: 1 = immediate operand B.
- ex_alufunc  out  ALUF_W  EX ALU function.
- ex_regdest  out  1  EX: 1 = rd is destination, 0 = rt.
- fwd_a, fwd_b  out  2  operand source: 00 regfile, 01 MEM result, 10 WB result.
- mem_read, mem_write  out  1  MEM data-memory strobes.
- wb_regwrite, wb_memtoreg  out  1  WB write enable and result select.
- wb_dest  out  REG_AW  WB destination register.
- pcsrc  out  1  redirect PC (combinational from EX).
- stall  out  1  hold PC and IF/ID this cycle.
- flush  out  1  discard IF/ID this cycle.
- illegal  out  1  sticky illegal-opcode flag.

## Operation
- Decode, op = instr[31:26]:
  - op[5:4]=00: R-type. ALU function from instr[5:0]: 1..10 map to 0..9 (ADD, SUB, AND, OR, XOR, NOT, SLA, SLL, SRA, SRL). Sets regdest=1, regwrite=1. Reads rs and rt.
  - 010000..011001: ADDI..SRLI map to function 0..9. 011010 MOVE maps to function 0. Sets alusrc=1, regwrite=1. Reads rs.
  - 100001 LD: alusrc, read, regwrite, memtoreg; function 0; reads rs. 100010 ST: alusrc, write; reads rs and rt.
  - 110000..110011 BLT/BGT/BEQ/BNE: branch; read rs and rt. 110100 BR: jump; reads rs.
  - Any other op, or an R-type func outside 1..10: zero control word (bubble) and sets illegal.
  - instr == 0 or instr_valid=0: bubble, illegal unaffected.
- Destination register: rd if regdest, else rt. A destination of r0 never creates a hazard or a forward.
- Stage registers EX/MEM/WB carry the control word plus dest/rs/rt, and advance every cycle.
- pcsrc = ex_jump | (ex_branch & branch_condition).
- flush = pcsrc. On the next edge, EX loads a bubble, and IF/ID contents are dropped by fetch.
- stall conditions:
  - FWD_EN=1: EX holds LD and its dest matches a source the ID instruction reads.
  - FWD_EN=0: EX or MEM has regwrite with dest matching an ID source.
  - On stall, EX loads a bubble and MEM/WB advance.
- flush has priority over stall; stall is forced to 0 when pcsrc=1.
- Forwarding (FWD_EN=1), evaluated for the EX rs (fwd_a) and EX rt (fwd_b):
  - 01 if MEM regwrite, MEM not a load, and MEM dest matches.
  - else 10 if WB regwrite and WB dest matches.
  - else 00.
  - FWD_EN=0: both selects tied to 00.
- illegal stays set until reset.

## Timing
- Reset: all stage registers hold a bubble. Every output is 0; fwd_a = fwd_b = 00; wb_dest = 0.
- Decode is combinational in ID. Control word reaches EX outputs 1 edge later, MEM 2 edges, WB 3 edges.
- pcsrc, stall, flush and fwd_* are combinational in the same cycle as the EX/ID contents that produce them.
- Load-use costs exactly 1 bubble cycle with FWD_EN=1. RAW costs up to 2 with FWD_EN=0.
- Taken branch/jump: 2 instructions squashed (ID and IF).
- Reset asserted mid-operation: all stages become bubbles immediately, with no partial writeback.

## Test plan
- Reset then ADD r3,r1,r2 (func 000001): 1 cycle later ex_alufunc=0000, ex_regdest=1; 3 cycles later wb_regwrite=1, wb_dest=3.
- LD r5 then ADD r6,r5,r1 with FWD_EN=1: stall=1 for exactly 1 cycle, then fwd_a=10 when ADD is in EX.
- ADDI r4 then SUB r7,r4,r4: no stall; fwd_a=fwd_b=01 with SUB in EX.
- BEQ in EX with branch_condition=1: pcsrc=flush=1 for 1 cycle, following ID instruction never reaches EX. The same case with branch_condition=0 gives pcsrc=0.
- Opcode 111111: control word zero, illegal=1 and held across 10 cycles until reset.
- FWD_EN=0, ADD r3 then OR r8,r3,r0: stall for 2 cycles, fwd_* stay 00; a destination of r0 never stalls.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for KGP-RISC: ID decode, EX/MEM/WB control stage registers, hazard/forward/flush/trap logic.
// Latency: the control word is visible at EX 1 edge after ID, MEM after 2, WB after 3; pcsrc/stall/flush/fwd_* are combinational.
// Backpressure: stall holds PC and IF/ID and loads an EX bubble; flush (higher priority) squashes ID and IF.
//
// Ports:
//   clk, reset (async, active-high)    : clock and stage-register clear
//   instr, instr_valid                 : IF/ID contents; invalid or all-zero decodes as a bubble
//   branch_condition                   : EX-stage ALU comparison result
//   ex_alusrc, ex_alufunc, ex_regdest  : EX control
//   fwd_a, fwd_b                       : EX operand source (00 regfile, 01 MEM result, 10 WB result)
//   mem_read, mem_write                : MEM data-memory strobes
//   wb_regwrite, wb_memtoreg, wb_dest  : WB control
//   pcsrc, stall, flush, illegal       : PC redirect, IF/ID hold, IF/ID discard, sticky trap flag
module pipe_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int ALUF_W = 4,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic              branch_condition,
    output logic              ex_alusrc,
    output logic [ALUF_W-1:0] ex_alufunc,
    output logic              ex_regdest,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] wb_dest,
    output logic              pcsrc,
    output logic              stall,
    output logic              flush,
    output logic              illegal
);

    // Control word carried down the pipe. rs/rt are zeroed when the
    // instruction does not read that field, and dest is zeroed when it does
    // not write, so r0 comparisons can never produce a hazard or a forward.
    typedef struct packed {
        logic              alusrc;
        logic [ALUF_W-1:0] alufunc;
        logic              regdest;
        logic              regwrite;
        logic              memtoreg;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [5:0] OP_ADDI = 6'h10;
    localparam logic [5:0] OP_SRLI = 6'h19;
    localparam logic [5:0] OP_MOVE = 6'h1A;
    localparam logic [5:0] OP_LD   = 6'h21;
    localparam logic [5:0] OP_ST   = 6'h22;
    localparam logic [5:0] OP_BLT  = 6'h30;
    localparam logic [5:0] OP_BNE  = 6'h33;
    localparam logic [5:0] OP_BR   = 6'h34;

    ctrl_t ex_q, ex_d;
    ctrl_t mem_q, mem_d;
    ctrl_t wb_q, wb_d;
    logic  illegal_q, illegal_d;

    ctrl_t id_ctrl;
    logic  id_illegal;
    logic  raw_hazard;

    // Every instruction bit is either decoded or deliberately ignored
    // (immediates, shamt); the same holds for WB fields nothing consumes.
    logic unused_bits;
    assign unused_bits = ^{instr, wb_q};

    function automatic logic reg_hit(input logic [REG_AW-1:0] dest,
                                     input logic [REG_AW-1:0] src);
        return (dest != '0) && (dest == src);
    endfunction

    // MEM result wins over WB (it is younger); a load in MEM has no result yet.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input ctrl_t mem_c,
                                           input ctrl_t wb_c);
        if (mem_c.regwrite && !mem_c.mem_read && reg_hit(mem_c.dest, src)) begin
            return 2'b01;
        end else if (wb_c.regwrite && reg_hit(wb_c.dest, src)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // ID decode
    always_comb begin
        logic [5:0]        op;
        logic [5:0]        func;
        logic [REG_AW-1:0] f_rs;
        logic [REG_AW-1:0] f_rt;
        logic [REG_AW-1:0] f_rd;
        logic              reads_rs;
        logic              reads_rt;

        id_ctrl    = CTRL_BUBBLE;
        id_illegal = 1'b0;
        reads_rs   = 1'b0;
        reads_rt   = 1'b0;
        op         = instr[31:26];
        func       = instr[5:0];
        f_rs       = instr[21 +: REG_AW];
        f_rt       = instr[16 +: REG_AW];
        f_rd       = instr[11 +: REG_AW];

        if (instr_valid && (instr != 32'd0)) begin
            if (op[5:4] == 2'b00) begin
                if ((func >= 6'd1) && (func <= 6'd10)) begin
                    id_ctrl.alufunc  = ALUF_W'(func - 6'd1);
                    id_ctrl.regdest  = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                    reads_rs         = 1'b1;
                    reads_rt         = 1'b1;
                end else begin
                    id_illegal = 1'b1;
                end
            end else if ((op >= OP_ADDI) && (op <= OP_SRLI)) begin
                id_ctrl.alufunc  = ALUF_W'(op - OP_ADDI);
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.regwrite = 1'b1;
                reads_rs         = 1'b1;
            end else if (op == OP_MOVE) begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.regwrite = 1'b1;
                reads_rs         = 1'b1;
            end else if (op == OP_LD) begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.mem_read = 1'b1;
                id_ctrl.regwrite = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                reads_rs         = 1'b1;
            end else if (op == OP_ST) begin
                id_ctrl.alusrc    = 1'b1;
                id_ctrl.mem_write = 1'b1;
                reads_rs          = 1'b1;
                reads_rt          = 1'b1;
            end else if ((op >= OP_BLT) && (op <= OP_BNE)) begin
                id_ctrl.branch = 1'b1;
                reads_rs       = 1'b1;
                reads_rt       = 1'b1;
            end else if (op == OP_BR) begin
                id_ctrl.jump = 1'b1;
                reads_rs     = 1'b1;
            end else begin
                id_illegal = 1'b1;
            end
        end

        if (id_ctrl.regwrite) begin
            id_ctrl.dest = id_ctrl.regdest ? f_rd : f_rt;
        end
        id_ctrl.rs = reads_rs ? f_rs : '0;
        id_ctrl.rt = reads_rt ? f_rt : '0;
    end

    // Hazards, redirect and forwarding selects
    always_comb begin
        logic id_uses_ex;
        logic id_uses_mem;

        id_uses_ex  = reg_hit(ex_q.dest, id_ctrl.rs) || reg_hit(ex_q.dest, id_ctrl.rt);
        id_uses_mem = reg_hit(mem_q.dest, id_ctrl.rs) || reg_hit(mem_q.dest, id_ctrl.rt);

        if (FWD_EN != 0) begin
            raw_hazard = ex_q.mem_read && id_uses_ex;
        end else begin
            raw_hazard = (ex_q.regwrite && id_uses_ex) || (mem_q.regwrite && id_uses_mem);
        end

        pcsrc = ex_q.jump || (ex_q.branch && branch_condition);
        flush = pcsrc;
        // The ID instruction is wrong-path when redirecting, so its hazard is moot.
        stall = raw_hazard && !pcsrc;

        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN != 0) begin
            fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
            fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);
        end
    end

    // Next-state for stage registers
    always_comb begin
        ex_d      = (pcsrc || stall) ? CTRL_BUBBLE : id_ctrl;
        mem_d     = ex_q;
        wb_d      = mem_q;
        // A wrong-path opcode being squashed must not raise the trap.
        illegal_d = illegal_q || (id_illegal && !pcsrc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q      <= CTRL_BUBBLE;
            mem_q     <= CTRL_BUBBLE;
            wb_q      <= CTRL_BUBBLE;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_alusrc   = ex_q.alusrc;
    assign ex_alufunc  = ex_q.alufunc;
    assign ex_regdest  = ex_q.regdest;
    assign mem_read    = mem_q.mem_read;
    assign mem_write   = mem_q.mem_write;
    assign wb_regwrite = wb_q.regwrite;
    assign wb_memtoreg = wb_q.memtoreg;
    assign wb_dest     = wb_q.dest;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with forwarding, one without, sharing stimulus.
// Expectations are queued with the cycle they fall due and compared when that cycle is sampled.
// IF/ID hold on stall is emulated by re-driving the same instruction.
module tb_pipe_ctrl_unit;

    localparam int AW = 5;
    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        branch_condition;

    always #5 clk = ~clk;

    logic          a_ex_alusrc, a_ex_regdest, a_mem_read, a_mem_write;
    logic          a_wb_regwrite, a_wb_memtoreg, a_pcsrc, a_stall, a_flush, a_illegal;
    logic [FW-1:0] a_ex_alufunc;
    logic [1:0]    a_fwd_a, a_fwd_b;
    logic [AW-1:0] a_wb_dest;

    logic          b_ex_alusrc, b_ex_regdest, b_mem_read, b_mem_write;
    logic          b_wb_regwrite, b_wb_memtoreg, b_pcsrc, b_stall, b_flush, b_illegal;
    logic [FW-1:0] b_ex_alufunc;
    logic [1:0]    b_fwd_a, b_fwd_b;
    logic [AW-1:0] b_wb_dest;

    pipe_ctrl_unit #(.REG_AW(AW), .ALUF_W(FW), .FWD_EN(1)) u_fwd (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .branch_condition(branch_condition),
        .ex_alusrc(a_ex_alusrc), .ex_alufunc(a_ex_alufunc), .ex_regdest(a_ex_regdest),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .wb_regwrite(a_wb_regwrite), .wb_memtoreg(a_wb_memtoreg), .wb_dest(a_wb_dest),
        .pcsrc(a_pcsrc), .stall(a_stall), .flush(a_flush), .illegal(a_illegal)
    );

    pipe_ctrl_unit #(.REG_AW(AW), .ALUF_W(FW), .FWD_EN(0)) u_nofwd (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .branch_condition(branch_condition),
        .ex_alusrc(b_ex_alusrc), .ex_alufunc(b_ex_alufunc), .ex_regdest(b_ex_regdest),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .wb_regwrite(b_wb_regwrite), .wb_memtoreg(b_wb_memtoreg), .wb_dest(b_wb_dest),
        .pcsrc(b_pcsrc), .stall(b_stall), .flush(b_flush), .illegal(b_illegal)
    );

    localparam int S_EX_ALUSRC  = 0;
    localparam int S_EX_ALUF    = 1;
    localparam int S_EX_REGDEST = 2;
    localparam int S_FWD_A      = 3;
    localparam int S_FWD_B      = 4;
    localparam int S_MEM_RD     = 5;
    localparam int S_MEM_WR     = 6;
    localparam int S_WB_RW      = 7;
    localparam int S_WB_M2R     = 8;
    localparam int S_WB_DEST    = 9;
    localparam int S_PCSRC      = 10;
    localparam int S_STALL      = 11;
    localparam int S_FLUSH      = 12;
    localparam int S_ILLEGAL    = 13;
    localparam int N_SEL        = 14;
    localparam int B            = 16;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_EX_ALUSRC:      return 32'(a_ex_alusrc);
            S_EX_ALUF:        return 32'(a_ex_alufunc);
            S_EX_REGDEST:     return 32'(a_ex_regdest);
            S_FWD_A:          return 32'(a_fwd_a);
            S_FWD_B:          return 32'(a_fwd_b);
            S_MEM_RD:         return 32'(a_mem_read);
            S_MEM_WR:         return 32'(a_mem_write);
            S_WB_RW:          return 32'(a_wb_regwrite);
            S_WB_M2R:         return 32'(a_wb_memtoreg);
            S_WB_DEST:        return 32'(a_wb_dest);
            S_PCSRC:          return 32'(a_pcsrc);
            S_STALL:          return 32'(a_stall);
            S_FLUSH:          return 32'(a_flush);
            S_ILLEGAL:        return 32'(a_illegal);
            B + S_EX_ALUSRC:  return 32'(b_ex_alusrc);
            B + S_EX_ALUF:    return 32'(b_ex_alufunc);
            B + S_EX_REGDEST: return 32'(b_ex_regdest);
            B + S_FWD_A:      return 32'(b_fwd_a);
            B + S_FWD_B:      return 32'(b_fwd_b);
            B + S_MEM_RD:     return 32'(b_mem_read);
            B + S_MEM_WR:     return 32'(b_mem_write);
            B + S_WB_RW:      return 32'(b_wb_regwrite);
            B + S_WB_M2R:     return 32'(b_wb_memtoreg);
            B + S_WB_DEST:    return 32'(b_wb_dest);
            B + S_PCSRC:      return 32'(b_pcsrc);
            B + S_STALL:      return 32'(b_stall);
            B + S_FLUSH:      return 32'(b_flush);
            B + S_ILLEGAL:    return 32'(b_illegal);
            default:          return 32'hDEAD_BEEF;
        endcase
    endfunction

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] rtype(input logic [5:0] f, input int rs, input int rt, input int rd);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    task automatic expect_at(input int dly, input int sel, input logic [31:0] val, input string tag);
        exp_t e;
        e.due = cyc + dly;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic [31:0] i, input logic v, input logic bc);
        @(negedge clk);
        reset            = rst;
        instr            = i;
        instr_valid      = v;
        branch_condition = bc;
        cyc++;
    endtask

    task automatic sample();
        exp_t        keep[$];
        logic [31:0] o;
        #2;
        foreach (sb[k]) begin
            if (sb[k].due == cyc) begin
                o = obs(sb[k].sel);
                checks++;
                assert (o === sb[k].val)
                else begin
                    errors++;
                    $error("FAIL %s at step %0d: observed %0h expected %0h", sb[k].tag, cyc, o, sb[k].val);
                end
            end else begin
                keep.push_back(sb[k]);
            end
        end
        sb = keep;
    endtask

    task automatic bubbles(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b0);
            sample();
        end
    endtask

    initial begin
        reset            = 1'b1;
        instr            = 32'd0;
        instr_valid      = 1'b0;
        branch_condition = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state: every output of both instances is zero
        drive(1'b1, 32'd0, 1'b0, 1'b0);
        for (int s = 0; s < N_SEL; s++) begin
            expect_at(0, s, 32'd0, $sformatf("reset_fwd_sel%0d", s));
            expect_at(0, B + s, 32'd0, $sformatf("reset_nofwd_sel%0d", s));
        end
        sample();

        // ADD r3,r1,r2 flows to EX then WB
        drive(1'b0, rtype(6'd1, 1, 2, 3), 1'b1, 1'b0);
        expect_at(0, S_STALL, 0, "add_no_stall");
        expect_at(1, S_EX_ALUF, 0, "add_ex_alufunc");
        expect_at(1, S_EX_REGDEST, 1, "add_ex_regdest");
        expect_at(1, S_EX_ALUSRC, 0, "add_ex_alusrc");
        expect_at(3, S_WB_RW, 1, "add_wb_regwrite");
        expect_at(3, S_WB_DEST, 3, "add_wb_dest");
        expect_at(3, S_WB_M2R, 0, "add_wb_memtoreg");
        sample();
        bubbles(3);

        // instr==0 and invalid instructions are bubbles, not traps
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        expect_at(1, S_EX_REGDEST, 0, "zero_instr_bubble");
        sample();
        drive(1'b0, {6'b111111, 26'd0}, 1'b0, 1'b0);
        expect_at(2, S_ILLEGAL, 0, "invalid_not_illegal");
        sample();

        // LD r5 then ADD r6,r5,r1: one stall, then WB forward
        drive(1'b0, itype(6'h21, 1, 5), 1'b1, 1'b0);
        expect_at(0, S_STALL, 0, "ld_in_id_no_stall");
        sample();
        drive(1'b0, rtype(6'd1, 5, 1, 6), 1'b1, 1'b0);
        expect_at(0, S_STALL, 1, "loaduse_stall");
        expect_at(0, S_EX_ALUSRC, 1, "ld_ex_alusrc");
        sample();
        drive(1'b0, rtype(6'd1, 5, 1, 6), 1'b1, 1'b0);
        expect_at(0, S_STALL, 0, "loaduse_single_bubble");
        expect_at(0, S_MEM_RD, 1, "ld_mem_read");
        expect_at(0, S_EX_REGDEST, 0, "loaduse_ex_bubble");
        sample();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        expect_at(0, S_FWD_A, 2, "loaduse_fwd_a_wb");
        expect_at(0, S_FWD_B, 0, "loaduse_fwd_b_none");
        expect_at(0, S_EX_REGDEST, 1, "add_after_ld_in_ex");
        expect_at(0, S_WB_M2R, 1, "ld_wb_memtoreg");
        expect_at(0, S_WB_DEST, 5, "ld_wb_dest");
        sample();
        bubbles(3);

        // ADDI r4 then SUB r7,r4,r4: no stall, MEM forward on both operands
        drive(1'b0, itype(6'h10, 1, 4), 1'b1, 1'b0);
        sample();
        drive(1'b0, rtype(6'd2, 4, 4, 7), 1'b1, 1'b0);
        expect_at(0, S_STALL, 0, "addi_sub_no_stall");
        expect_at(0, S_EX_ALUSRC, 1, "addi_ex_alusrc");
        sample();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        expect_at(0, S_FWD_A, 1, "sub_fwd_a_mem");
        expect_at(0, S_FWD_B, 1, "sub_fwd_b_mem");
        expect_at(0, S_EX_ALUF, 1, "sub_ex_alufunc");
        sample();
        bubbles(3);

        // BEQ taken: one-cycle redirect, following instruction squashed
        drive(1'b0, itype(6'h32, 1, 2), 1'b1, 1'b0);
        sample();
        drive(1'b0, rtype(6'd1, 1, 2, 9), 1'b1, 1'b1);
        expect_at(0, S_PCSRC, 1, "beq_taken_pcsrc");
        expect_at(0, S_FLUSH, 1, "beq_taken_flush");
        expect_at(0, S_STALL, 0, "beq_taken_no_stall");
        sample();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        expect_at(0, S_PCSRC, 0, "pcsrc_one_cycle");
        expect_at(0, S_EX_REGDEST, 0, "squashed_not_in_ex");
        expect_at(2, S_WB_RW, 0, "squashed_no_wb");
        sample();
        bubbles(3);

        // BEQ not taken: following instruction proceeds
        drive(1'b0, itype(6'h32, 1, 2), 1'b1, 1'b0);
        sample();
        drive(1'b0, rtype(6'd1, 1, 2, 9), 1'b1, 1'b0);
        expect_at(0, S_PCSRC, 0, "beq_not_taken_pcsrc");
        expect_at(0, S_FLUSH, 0, "beq_not_taken_flush");
        sample();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        expect_at(0, S_EX_REGDEST, 1, "not_taken_add_in_ex");
        expect_at(2, S_WB_DEST, 9, "not_taken_add_wb_dest");
        sample();
        bubbles(3);

        // BR jumps regardless of branch_condition
        drive(1'b0, itype(6'h34, 1, 0), 1'b1, 1'b0);
        sample();
        drive(1'b0, rtype(6'd1, 1, 2, 9), 1'b1, 1'b0);
        expect_at(0, S_PCSRC, 1, "br_pcsrc");
        sample();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        expect_at(0, S_EX_REGDEST, 0, "br_squash_not_in_ex");
        sample();
        bubbles(3);

        // Illegal opcode: zero control word, sticky flag
        drive(1'b0, {6'b111111, 26'd0}, 1'b1, 1'b0);
        expect_at(0, S_ILLEGAL, 0, "illegal_before_edge");
        expect_at(1, S_ILLEGAL, 1, "illegal_set");
        expect_at(1, S_EX_ALUSRC, 0, "illegal_ex_alusrc");
        expect_at(1, S_EX_REGDEST, 0, "illegal_ex_regdest");
        expect_at(11, S_ILLEGAL, 1, "illegal_held");
        sample();
        bubbles(11);

        // Reset mid-operation: no partial writeback
        drive(1'b0, rtype(6'd1, 1, 2, 3), 1'b1, 1'b0);
        sample();
        drive(1'b0, rtype(6'd1, 1, 2, 4), 1'b1, 1'b0);
        sample();
        drive(1'b0, rtype(6'd1, 1, 2, 5), 1'b1, 1'b0);
        sample();
        drive(1'b1, 32'd0, 1'b0, 1'b0);
        expect_at(0, S_WB_RW, 0, "rst_mid_wb_regwrite");
        expect_at(0, S_WB_DEST, 0, "rst_mid_wb_dest");
        expect_at(0, S_EX_REGDEST, 0, "rst_mid_ex");
        expect_at(0, S_ILLEGAL, 0, "rst_clears_illegal");
        sample();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        expect_at(0, S_WB_RW, 0, "rst_no_partial_wb");
        sample();

        // Without forwarding: R-type func out of range traps
        drive(1'b0, rtype(6'd11, 1, 2, 3), 1'b1, 1'b0);
        expect_at(1, B + S_ILLEGAL, 1, "func11_illegal");
        expect_at(1, B + S_EX_REGDEST, 0, "func11_bubble");
        sample();

        // Without forwarding: ADD r3 then OR r8,r3,r0 stalls 2 cycles
        drive(1'b0, rtype(6'd1, 1, 2, 3), 1'b1, 1'b0);
        expect_at(0, B + S_STALL, 0, "nofwd_add_no_stall");
        sample();
        drive(1'b0, rtype(6'd4, 3, 0, 8), 1'b1, 1'b0);
        expect_at(0, B + S_STALL, 1, "nofwd_raw_stall_ex");
        expect_at(0, B + S_FWD_A, 0, "nofwd_fwd_a_stall1");
        sample();
        drive(1'b0, rtype(6'd4, 3, 0, 8), 1'b1, 1'b0);
        expect_at(0, B + S_STALL, 1, "nofwd_raw_stall_mem");
        expect_at(0, B + S_FWD_B, 0, "nofwd_fwd_b_stall2");
        sample();
        drive(1'b0, rtype(6'd4, 3, 0, 8), 1'b1, 1'b0);
        expect_at(0, B + S_STALL, 0, "nofwd_raw_stall_done");
        sample();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        expect_at(0, B + S_EX_REGDEST, 1, "nofwd_or_in_ex");
        expect_at(0, B + S_EX_ALUF, 3, "nofwd_or_alufunc");
        expect_at(0, B + S_FWD_A, 0, "nofwd_fwd_a_tied");
        sample();
        bubbles(3);

        // r0 destination never stalls or forwards
        drive(1'b0, itype(6'h10, 1, 0), 1'b1, 1'b0);
        sample();
        drive(1'b0, rtype(6'd1, 0, 0, 9), 1'b1, 1'b0);
        expect_at(0, B + S_STALL, 0, "r0_no_stall_ex");
        sample();
        drive(1'b0, rtype(6'd1, 0, 0, 10), 1'b1, 1'b0);
        expect_at(0, B + S_STALL, 0, "r0_no_stall_mem");
        expect_at(0, S_FWD_A, 0, "r0_no_fwd_a");
        sample();
        bubbles(3);

        // Flush beats stall without forwarding
        drive(1'b0, rtype(6'd1, 1, 2, 3), 1'b1, 1'b0);
        sample();
        drive(1'b0, itype(6'h32, 5, 6), 1'b1, 1'b0);
        expect_at(0, B + S_STALL, 0, "beq_id_no_stall");
        sample();
        drive(1'b0, rtype(6'd4, 3, 0, 8), 1'b1, 1'b1);
        expect_at(0, B + S_STALL, 0, "flush_beats_stall");
        expect_at(0, B + S_FLUSH, 1, "nofwd_flush");
        expect_at(0, B + S_PCSRC, 1, "nofwd_pcsrc");
        sample();
        bubbles(4);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
